// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small input FIFO and a valid/ready write port.
module uart_tx #(
    parameter int unsigned BAUD_RATE    = 9_600,
    parameter int unsigned SYS_CLK_FREQ = 48_000_000,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       tx,
    output logic       busy
);

    localparam int unsigned BIT_PERIOD = SYS_CLK_FREQ / BAUD_RATE;
    localparam int unsigned TIMER_W    = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
    localparam int unsigned PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W      = PTR_W + 1;
    localparam logic [TIMER_W-1:0] TIMER_RELOAD = TIMER_W'(BIT_PERIOD - 1);
    localparam logic [CNT_W-1:0]   FIFO_FULL    = CNT_W'(FIFO_DEPTH);

    // Elaboration-time parameter sanity
    if (BIT_PERIOD < 2) begin : g_bad_bit_period
        $error("uart_tx: SYS_CLK_FREQ / BAUD_RATE must be at least 2");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("uart_tx: FIFO_DEPTH must be a power of 2 and at least 2");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic                 tx_q, tx_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [2:0]           bit_q, bit_d;
    logic [7:0]           shift_q, shift_d;
    logic                 pop;

    logic [7:0]           mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 ready_q, busy_q;
    logic                 wr_en;
    logic [7:0]           head;

    assign wr_en      = data_valid && ready_q;
    assign head       = mem[rd_ptr_q];
    assign count_d    = count_q + CNT_W'(wr_en) - CNT_W'(pop);

    assign data_ready = ready_q;
    assign tx         = tx_q;
    assign busy       = busy_q;

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, line level, bit timer and FIFO pop decisions
    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        timer_d = timer_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (count_q != '0) begin
                    pop     = 1'b1;
                    shift_d = head;
                    tx_d    = 1'b0;
                    timer_d = TIMER_RELOAD;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (timer_q == '0) begin
                    tx_d    = shift_q[0];
                    bit_d   = 3'd0;
                    timer_d = TIMER_RELOAD;
                    state_d = S_DATA;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
            S_DATA: begin
                if (timer_q == '0) begin
                    timer_d = TIMER_RELOAD;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        bit_d = 3'(bit_q + 3'd1);
                        tx_d  = shift_q[3'(bit_q + 3'd1)];
                    end
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
            S_STOP: begin
                if (timer_q == '0) begin
                    if (count_q != '0) begin
                        // Chain straight into the next frame with no idle gap
                        pop     = 1'b1;
                        shift_d = head;
                        tx_d    = 1'b0;
                        timer_d = TIMER_RELOAD;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // Serialiser datapath registers; tx resets high so the line idles cleanly
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_q    <= 1'b1;
            timer_q <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            tx_q    <= tx_d;
            timer_q <= timer_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    // FIFO pointers, occupancy and the registered ready/busy flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
            ready_q <= (count_d < FIFO_FULL);
            busy_q  <= (state_d != S_IDLE) || (count_d != '0);
        end
    end

    // FIFO storage; contents need no reset since occupancy is tracked by count
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= data_in;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed vectors, corner sequences, random traffic.
module tb_uart_tx;

    localparam int unsigned BIT_P = 10;
    localparam int unsigned FRAME = 10 * BIT_P;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       data_valid = 1'b0;
    logic       data_ready;
    logic       tx;
    logic       busy;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    // Reference model state: bytes the line must carry, in order
    logic [7:0] exp_q[$];
    int         start_q[$];

    // Line receiver model state
    logic       rx_active = 1'b0;
    int         rx_cnt = 0;
    logic       rx_err = 1'b0;
    logic [9:0] rx_bits = '0;
    logic [9:0] last_frame = '0;
    int         last_start = -1;

    uart_tx #(
        .BAUD_RATE   (100_000),
        .SYS_CLK_FREQ(1_000_000),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .data_in   (data_in),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .tx        (tx),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Line decoder: every bit must hold for exactly BIT_P cycles; decoded bytes must match the queue
    always @(negedge clk) begin : rx_model
        int bitn;
        if (!reset_n) begin
            rx_active = 1'b0;
        end else begin
            if (!rx_active && tx == 1'b0) begin
                rx_active = 1'b1;
                rx_cnt    = 0;
                rx_err    = 1'b0;
                start_q.push_back(cyc);
                last_start = cyc;
            end
            if (rx_active) begin
                bitn = rx_cnt / BIT_P;
                if (rx_cnt % BIT_P == 0) rx_bits[bitn] = tx;
                else if (tx !== rx_bits[bitn]) rx_err = 1'b1;
                if (rx_cnt == FRAME - 1) begin
                    last_frame = rx_bits;
                    rx_active  = 1'b0;
                    if (exp_q.size() == 0) begin
                        check("rx_unexpected_frame", 32'(rx_bits), 32'h3ff);
                        check("rx_unexpected_count", 32'd1, 32'd0);
                    end else begin
                        check("rx_frame", {21'd0, rx_err, rx_bits},
                              {21'd0, 1'b0, 1'b1, exp_q.pop_front(), 1'b0});
                    end
                end else begin
                    rx_cnt++;
                end
            end
        end
    end

    // Present a byte (called just after a negedge); returns just after the negedge following acceptance
    task automatic send(input logic [7:0] b, output int acc);
        int n = 0;
        data_in    = b;
        data_valid = 1'b1;
        while (!data_ready && n < 3000) begin
            @(negedge clk);
            data_in = 8'($urandom);
            n++;
        end
        if (n >= 3000) begin
            check("send_timeout", 32'(n), 32'd0);
            data_valid = 1'b0;
            acc = cyc;
            return;
        end
        exp_q.push_back(data_in);
        @(negedge clk);
        acc        = cyc;
        data_valid = 1'b0;
        data_in    = 8'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while ((busy || rx_active) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 32'(n >= 5000), 32'd0);
    endtask

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
    } vec_t;

    initial begin : watchdog
        #900_000;
        $display("FAIL watchdog timeout got=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t vecs[4];
        int   acc;
        int   accs[6];
        int   lows;
        logic [7:0] b2b[5];

        vecs[0] = '{8'hA5, 10'b1_1010_0101_0};
        vecs[1] = '{8'h3C, 10'b1_0011_1100_0};
        vecs[2] = '{8'h01, 10'b1_0000_0001_0};
        vecs[3] = '{8'hFE, 10'b1_1111_1110_0};
        b2b[0] = 8'h00; b2b[1] = 8'hFF; b2b[2] = 8'h55; b2b[3] = 8'h3C; b2b[4] = 8'h81;

        // Power-on reset, asserted away from any clock edge
        #1 reset_n = 1'b0;
        #1;
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_ready", 32'(data_ready), 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("ready_after_release", 32'(data_ready), 32'd1);

        // Directed single-frame vectors with exact latency and length
        for (int i = 0; i < 4; i++) begin
            send(vecs[i].data, acc);
            check("tx_high_at_accept", 32'(tx), 32'd1);
            check("busy_at_accept", 32'(busy), 32'd1);
            @(negedge clk);
            check("tx_start_latency", 32'(tx), 32'd0);
            while (cyc < acc + 100) @(negedge clk);
            check("busy_last_stop_cycle", 32'(busy), 32'd1);
            @(negedge clk);
            check("busy_after_frame", 32'(busy), 32'd0);
            check("tx_idle_after_frame", 32'(tx), 32'd1);
            check("vec_frame_bits", 32'(last_frame), 32'(vecs[i].frame));
            check("vec_start_cycle", 32'(last_start), 32'(acc + 1));
            repeat (5) @(negedge clk);
        end

        // Back-to-back writes: FIFO fills, frames chain with no gaps
        start_q.delete();
        for (int i = 0; i < 5; i++) send(b2b[i], accs[i]);
        check("b2b_ready_full", 32'(data_ready), 32'd0);
        check("b2b_consecutive_accepts", 32'(accs[4] - accs[0]), 32'd4);
        drain();
        check("b2b_frame_count", 32'(start_q.size()), 32'd5);
        check("b2b_first_start", 32'(start_q[0]), 32'(accs[0] + 1));
        for (int i = 1; i < 5 && i < start_q.size(); i++)
            check("b2b_frame_gap", 32'(start_q[i] - start_q[i-1]), 32'(FRAME));

        // Write landing exactly on the STOP-to-START pop edge with two bytes queued
        repeat (3) @(negedge clk);
        start_q.delete();
        send(8'h11, accs[0]);
        send(8'h22, accs[1]);
        send(8'h33, accs[2]);
        while (cyc < accs[0] + 100) @(negedge clk);
        send(8'h44, accs[3]);
        check("sim_write_edge", 32'(accs[3]), 32'(accs[0] + 101));
        send(8'h55, accs[4]);
        send(8'h66, accs[5]);
        check("sim_count_kept", 32'(data_ready), 32'd0);
        drain();
        check("sim_frame_count", 32'(start_q.size()), 32'd6);
        if (start_q.size() >= 2)
            check("sim_no_gap", 32'(start_q[1] - start_q[0]), 32'(FRAME));

        // Randomised traffic; bursts hold valid against a full FIFO with changing data
        for (int i = 0; i < 30; i++) begin
            int gap;
            gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 120)) : 0;
            repeat (gap) begin
                data_in = 8'($urandom);
                @(negedge clk);
            end
            send(8'($urandom), acc);
        end
        drain();
        check("random_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset during data bit 4 of 0x0F with more bytes queued
        send(8'h0F, accs[0]);
        send(8'h77, accs[1]);
        send(8'h99, accs[2]);
        while (cyc < accs[0] + 55) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("midframe_reset_tx", 32'(tx), 32'd1);
        check("midframe_reset_busy", 32'(busy), 32'd0);
        check("midframe_reset_ready", 32'(data_ready), 32'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        lows = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        check("post_reset_tx_idle", 32'(lows), 32'd0);
        check("post_reset_ready", 32'(data_ready), 32'd1);
        check("post_reset_busy", 32'(busy), 32'd0);
        send(8'h42, acc);
        drain();
        check("post_reset_frame", 32'(last_frame), 32'(10'b1_0100_0010_0));
        check("post_reset_start", 32'(last_start), 32'(acc + 1));
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
